// File: rtl/alu_seq_n_bit_hs.sv
// Signed N-bit ALU with valid/ready handshakes: add/sub/logic resolve in one cycle,
// mul/div run a bit-serial magnitude sequencer for N cycles. One operation in flight.
module alu_seq_n_bit_hs #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic [N-1:0]   rem,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_v,
    output logic           flag_dz
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100, OP_OR = 3'b101, OP_XOR = 3'b110, OP_NOT = 3'b111;

    // LOAD is the operand-staging cycle: magnitudes are formed and one-cycle ops resolve.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             en_q;
    logic [2:0]       op_q;
    logic [N-1:0]     a_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic [2*N-1:0]   acc_q, mcand_q;
    logic [N-1:0]     sh_q, dvs_q;
    logic [N:0]       prem_q;
    logic [2*N-1:0]   res_q;
    logic [N-1:0]     rem_q;
    logic             z_q, n_q, v_q, dz_q;

    logic             is_seq, neg, ld, ge;
    logic [2*N-1:0]   acc_nx, qext, fin_res;
    logic [N:0]       rsh, prem_nx, sum;
    logic [N-1:0]     quo_nx, fin_rem, lres;
    logic             fin_v, fin_dz;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        return v[N-1] ? (~v + N'(1)) : v;
    endfunction

    assign is_seq = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign neg    = a_q[N-1] ^ b_q[N-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid && in_ready) state_d = S_LOAD;
            S_LOAD: state_d = is_seq ? S_EXEC : S_DONE;
            S_EXEC: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && en_q;
        out_valid = (state_q == S_DONE);
    end

    // One shift-add step for mul, one restoring-division step for div.
    always_comb begin
        acc_nx  = acc_q + (sh_q[0] ? mcand_q : '0);
        rsh     = {prem_q[N-1:0], sh_q[N-1]};
        ge      = (rsh >= {1'b0, dvs_q});
        prem_nx = ge ? (rsh - {1'b0, dvs_q}) : rsh;
        quo_nx  = {sh_q[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
        if (state_q == S_LOAD) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            prem_q  <= '0;
            mcand_q <= {{N{1'b0}}, mag(a_q)};
            dvs_q   <= mag(b_q);
            sh_q    <= (op_q == OP_MUL) ? mag(b_q) : mag(a_q);
        end else if (state_q == S_EXEC) begin
            cnt_q   <= cnt_q + CW'(1);
            acc_q   <= acc_nx;
            prem_q  <= prem_nx;
            mcand_q <= mcand_q << 1;
            sh_q    <= (op_q == OP_MUL) ? (sh_q >> 1) : quo_nx;
        end
    end

    always_comb begin
        fin_res = '0;
        fin_rem = '0;
        fin_v   = 1'b0;
        fin_dz  = 1'b0;
        sum     = (op_q == OP_SUB) ? ({a_q[N-1], a_q} - {b_q[N-1], b_q})
                                   : ({a_q[N-1], a_q} + {b_q[N-1], b_q});
        qext    = {{N{1'b0}}, quo_nx};
        lres    = '0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                fin_res = {{(N-1){sum[N]}}, sum};
                fin_v   = sum[N] ^ sum[N-1];
            end
            OP_MUL: fin_res = neg ? (~acc_nx + 1'b1) : acc_nx;
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_res = '1;
                    fin_rem = a_q;
                    fin_dz  = 1'b1;
                end else begin
                    fin_res = neg ? (~qext + 1'b1) : qext;
                    fin_rem = a_q[N-1] ? (~prem_nx[N-1:0] + N'(1)) : prem_nx[N-1:0];
                end
            end
            default: begin
                case (op_q)
                    OP_AND:  lres = a_q & b_q;
                    OP_OR:   lres = a_q | b_q;
                    OP_XOR:  lres = a_q ^ b_q;
                    OP_NOT:  lres = ~a_q;
                    default: lres = '0;
                endcase
                fin_res = {{N{lres[N-1]}}, lres};
            end
        endcase
    end

    assign ld = ((state_q == S_LOAD) && !is_seq) || ((state_q == S_EXEC) && (cnt_q == LAST));

    // Result and flags are registered together so they stay frozen while DONE waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
            rem_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            dz_q  <= 1'b0;
        end else if (ld) begin
            res_q <= fin_res;
            rem_q <= fin_rem;
            z_q   <= (fin_res == '0);
            n_q   <= fin_res[2*N-1];
            v_q   <= fin_v;
            dz_q  <= fin_dz;
        end
    end

    assign result  = res_q;
    assign rem     = rem_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;
    assign flag_v  = v_q;
    assign flag_dz = dz_q;
endmodule

// File: tb/tb_alu_seq_n_bit_hs.sv
// Scoreboard bench for alu_seq_n_bit_hs at N=4: directed corner cases, backpressure,
// reset abort, then randomized operations against an integer-arithmetic reference model.
module tb_alu_seq_n_bit_hs;
    localparam int N  = 4;
    localparam int W2 = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    op;
    logic [N-1:0]  a, b, rem;
    logic [W2-1:0] result;
    logic          flag_z, flag_n, flag_v, flag_dz;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rnd_rdy = 1'b0;

    typedef struct {
        logic [W2-1:0] res;
        logic [N-1:0]  rem;
        logic          z, n, v, dz;
        int            lat;
        int            acc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    bit   seen = 1'b0;
    int   first = 0;

    alu_seq_n_bit_hs #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rem(rem), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic exp_t model(input logic [2:0] o, input int av, input int bv);
        exp_t e;
        int r;
        e.rem = '0; e.v = 1'b0; e.dz = 1'b0; e.acc = 0;
        r = 0;
        case (o)
            3'd0: begin r = av + bv; e.v = (r > (1 << (N-1)) - 1) || (r < -(1 << (N-1))); end
            3'd1: begin r = av - bv; e.v = (r > (1 << (N-1)) - 1) || (r < -(1 << (N-1))); end
            3'd2: r = av * bv;
            3'd3: begin
                if (bv == 0) begin r = -1; e.rem = N'(av); e.dz = 1'b1; end
                else begin r = av / bv; e.rem = N'(av % bv); end
            end
            3'd4: r = av & bv;
            3'd5: r = av | bv;
            3'd6: r = av ^ bv;
            default: r = ~av;
        endcase
        e.res = W2'(r);
        e.z   = (r == 0);
        e.n   = (r < 0);
        e.lat = (o == 3'd2 || o == 3'd3) ? N + 1 : 1;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h with empty scoreboard", result);
                end else begin
                    me = q.pop_front();
                    check("latency", 32'(first - me.acc), 32'(me.lat));
                    check("result", 32'(result), 32'(me.res));
                    check("rem", 32'(rem), 32'(me.rem));
                    check("flags", {28'd0, flag_z, flag_n, flag_v, flag_dz},
                          {28'd0, me.z, me.n, me.v, me.dz});
                end
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [N-1:0] av, input logic [N-1:0] bv);
        exp_t e;
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = av; b = bv;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready got 0 expected 1");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        e = model(o, sx(av), sx(bv));
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = N'($urandom); b = N'($urandom);
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {26'd0, in_ready, out_valid, flag_z, flag_n, flag_v, flag_dz}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_rem", 32'(rem), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); check("ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk); check("ready_after_edge", 32'(in_ready), 32'd1);

        issue(3'd0, 4'd7, 4'd1);
        issue(3'd2, 4'h8, 4'h8);
        issue(3'd3, 4'h9, 4'd2);
        issue(3'd3, 4'h8, 4'hF);
        issue(3'd3, 4'd5, 4'd0);
        issue(3'd1, 4'h8, 4'd1);
        issue(3'd1, 4'd3, 4'd3);
        issue(3'd7, 4'h5, 4'h0);
        issue(3'd2, 4'h7, 4'h9);
        issue(3'd3, 4'h7, 4'hD);
        drain();

        @(posedge clk); #1 out_ready = 1'b0;
        issue(3'd4, 4'hC, 4'hA);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin @(negedge clk); t++; end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = N'($urandom); b = N'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'h00F8);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        drain();

        @(posedge clk); #1 in_valid = 1'b1; op = 3'd2; a = 4'h8; b = 4'h8;
        @(negedge clk); check("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {30'd0, in_ready, out_valid}, 32'd0);
        check("abort_result", 32'(result), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); check("abort_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk); check("abort_ready_high", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        issue(3'd0, 4'd3, 4'd2);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 60; i++)
            issue(3'($urandom), N'($urandom), N'($urandom));
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
